// File: rtl/qr_mat_ram.sv
// Multi-channel ROWS x COLS matrix store: per-channel row-block writes with written-bitmap
// tracking, sticky overwrite/address errors, and a row-major valid/ready read stream.
module qr_mat_ram #(
    parameter int DATA_W = 12,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int CH     = 8,
    parameter int SEG    = ROWS * COLS / CH,
    parameter int AW     = (SEG > 1) ? $clog2(SEG) : 1,
    parameter int CNT_W  = $clog2(ROWS * COLS + 1),
    parameter int IDX_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [CH-1:0]        wr_en,
    input  logic [CH*AW-1:0]     wr_addr,
    input  logic [CH*DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]     fill_cnt,
    output logic                 full,
    output logic                 ovw_err,
    output logic                 addr_err,
    input  logic                 rd_start,
    output logic                 rd_busy,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_W-1:0]    rd_data,
    output logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_last
);

    localparam int N = ROWS * COLS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Read handshake: an element transfers on any rising edge where rd_valid && rd_ready;
    // rd_valid, rd_data, rd_idx and rd_last come straight from registers and hold while stalled.
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic [N-1:0]      hit;
    logic [N-1:0]      written;
    logic [N-1:0]      newly;
    logic [CH-1:0]     bad_addr;
    logic [DATA_W-1:0] mem [N];

    genvar k, g;
    generate
        for (k = 0; k < CH; k++) begin : gen_ch
            assign bad_addr[k] = wr_en[k] && ({1'b0, wr_addr[k*AW +: AW]} >= (AW+1)'(SEG));
        end

        // Each entry decodes its own owning channel, so the channel blocks never collide.
        for (g = 0; g < N; g++) begin : gen_ent
            localparam int K = g / SEG;
            localparam int A = g % SEG;
            logic [DATA_W-1:0] val_q;
            logic              wr_q;

            assign hit[g] = wr_en[K] && (wr_addr[K*AW +: AW] == AW'(A));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_q <= '0;
                    wr_q  <= 1'b0;
                end else if (clr) begin
                    val_q <= '0;
                    wr_q  <= 1'b0;
                end else if (hit[g]) begin
                    val_q <= wr_data[K*DATA_W +: DATA_W];
                    wr_q  <= 1'b1;
                end
            end

            assign mem[g]     = val_q;
            assign written[g] = wr_q;
        end
    endgenerate

    assign newly = hit & ~written;

    logic [CNT_W-1:0] fill_q, fill_d;
    logic             ovw_q, ovw_d;
    logic             aerr_q, aerr_d;

    always_comb begin
        fill_d = fill_q + CNT_W'($countones(newly));
        ovw_d  = ovw_q | (|(hit & written));
        aerr_d = aerr_q | (|bad_addr);
        if (clr) begin
            fill_d = '0;
            ovw_d  = 1'b0;
            aerr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
            ovw_q  <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            ovw_q  <= ovw_d;
            aerr_q <= aerr_d;
        end
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  nxt_idx;

    // Loads read the registered contents, so a same-cycle write to the loaded entry yields the old value.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        nxt_idx = idx_q + 1'b1;
        if (clr) begin
            state_d = S_IDLE;
            data_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_start) begin
                        state_d = S_STREAM;
                        idx_d   = '0;
                        data_d  = mem[0];
                    end
                end
                S_STREAM: begin
                    if (rd_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d  = nxt_idx;
                            data_d = mem[nxt_idx];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == CNT_W'(N));
    assign ovw_err  = ovw_q;
    assign addr_err = aerr_q;
    assign rd_busy  = (state_q == S_STREAM);
    assign rd_valid = (state_q == S_STREAM);
    assign rd_data  = data_q;
    assign rd_idx   = idx_q;
    assign rd_last  = rd_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_qr_mat_ram.sv
// Directed bench for qr_mat_ram: default 8x8/8-channel instance plus a 4x3/2-channel
// instance for the out-of-range address case.
`timescale 1ns/1ps
module tb_qr_mat_ram;

  localparam int DW = 12;
  localparam int N  = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    wr_en = '0;
  logic [23:0]   wr_addr = '0;
  logic [95:0]   wr_data = '0;
  logic [6:0]    fill_cnt;
  logic          full, ovw_err, addr_err;
  logic          rd_start = 1'b0, rd_ready = 1'b0;
  logic          rd_busy, rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic [5:0]    rd_idx;

  logic [1:0]    s_wr_en = '0;
  logic [5:0]    s_wr_addr = '0;
  logic [23:0]   s_wr_data = '0;
  logic [3:0]    s_fill;
  logic          s_full, s_ovw, s_aerr;
  logic          s_rd_start = 1'b0, s_ready = 1'b0, s_clr = 1'b0;
  logic          s_busy, s_valid, s_last;
  logic [DW-1:0] s_data;
  logic [3:0]    s_idx;

  qr_mat_ram dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fill_cnt(fill_cnt), .full(full), .ovw_err(ovw_err), .addr_err(addr_err),
    .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_last(rd_last)
  );

  qr_mat_ram #(.DATA_W(12), .ROWS(4), .COLS(3), .CH(2)) dut_s (
    .clk(clk), .rst(rst), .clr(s_clr),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .fill_cnt(s_fill), .full(s_full), .ovw_err(s_ovw), .addr_err(s_aerr),
    .rd_start(s_rd_start), .rd_busy(s_busy), .rd_valid(s_valid), .rd_ready(s_ready),
    .rd_data(s_data), .rd_idx(s_idx), .rd_last(s_last)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [N];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wr();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic drive_write(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*3 +: 3] = 3'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready follows 1,0,0,1.
  // inj_idx >= 0: stall at that index and write idx 40 and idx 5 in the same cycle.
  task automatic run_stream(input int mode, input int inj_idx, input bit mid_start);
    int got;
    int cyc;
    bit stalled;
    bit injected;
    logic [DW-1:0] hold_d;
    logic [5:0] hold_i;
    got = 0;
    cyc = 0;
    stalled = 0;
    injected = 0;
    hold_d = '0;
    hold_i = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("start_valid", rd_valid, 1);
    chk("start_busy", rd_busy, 1);
    while (got < N && cyc < 400) begin
      if (stalled) begin
        chk("stall_data", rd_data, hold_d);
        chk("stall_idx", rd_idx, hold_i);
      end
      rd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (inj_idx >= 0 && !injected && int'(rd_idx) == inj_idx) begin
        rd_ready = 1'b0;
        injected = 1;
        drive_write(5, 0, 12'hABC);
        drive_write(0, 5, 12'h123);
        model[40] = 12'hABC;
        model[5] = 12'h123;
        exp_q[40 - inj_idx] = 12'hABC;
      end
      if (mid_start && cyc == 5) rd_start = 1'b1;
      if (rd_ready && rd_valid) begin
        chk("rd_data", rd_data, exp_q.pop_front());
        chk("rd_idx", rd_idx, got);
        chk("rd_last", rd_last, got == N - 1);
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        hold_d = rd_data;
        hold_i = rd_idx;
      end
      tick();
      clear_wr();
      rd_start = 1'b0;
      cyc++;
    end
    chk("stream_count", got, N);
    chk("end_valid", rd_valid, 0);
    chk("end_busy", rd_busy, 0);
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] en;
    int         a;
    int         fill;
    logic       full;
    logic       ovw;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_full", full, 0);
    chk("rst_ovw", ovw_err, 0);
    chk("rst_aerr", addr_err, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_last", rd_last, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < N; i++) model[i] = '0;

    for (int r = 0; r < 8; r++)
      vecs[r] = '{en: 8'hFF, a: r, fill: 8 * (r + 1), full: (r == 7), ovw: 1'b0};
    vecs[8] = '{en: 8'h00, a: 0, fill: 64, full: 1'b1, ovw: 1'b0};

    for (int v = 0; v < 9; v++) begin
      clear_wr();
      for (int k = 0; k < 8; k++) begin
        if (vecs[v].en[k]) begin
          drive_write(k, vecs[v].a, 12'(8 * k + vecs[v].a));
          model[8 * k + vecs[v].a] = 12'(8 * k + vecs[v].a);
        end
      end
      tick();
      clear_wr();
      chk("tbl_fill", fill_cnt, vecs[v].fill);
      chk("tbl_full", full, vecs[v].full);
      chk("tbl_ovw", ovw_err, vecs[v].ovw);
      chk("tbl_aerr", addr_err, 0);
    end

    run_stream(0, -1, 0);

    // rewrite of an already written entry: idx 29 = channel 3, a=5
    drive_write(3, 5, 12'h7E5);
    model[29] = 12'h7E5;
    tick();
    clear_wr();
    chk("rew_ovw", ovw_err, 1);
    chk("rew_fill", fill_cnt, 64);
    chk("rew_full", full, 1);

    run_stream(1, -1, 1);
    run_stream(0, 10, 0);

    // clr mid-stream at idx 20, with a write in the same cycle that must be dropped
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 100 && rd_idx != 6'd20; c++) tick();
    chk("clr_reach20", rd_idx, 20);
    clr = 1'b1;
    drive_write(2, 2, 12'h0F0);
    tick();
    clr = 1'b0;
    clear_wr();
    chk("clr_valid", rd_valid, 0);
    chk("clr_busy", rd_busy, 0);
    chk("clr_fill", fill_cnt, 0);
    chk("clr_full", full, 0);
    chk("clr_ovw", ovw_err, 0);
    chk("clr_aerr", addr_err, 0);
    rd_ready = 1'b0;

    drive_write(0, 0, 12'h011);
    tick();
    drive_write(0, 0, 12'h022);
    tick();
    clear_wr();
    chk("pre_rst_fill", fill_cnt, 1);
    chk("pre_rst_ovw", ovw_err, 1);

    // asynchronous reset mid-stream at idx 3
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 100 && rd_idx != 6'd3; c++) tick();
    chk("rst_reach3", rd_idx, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_busy", rd_busy, 0);
    chk("arst_data", rd_data, 0);
    chk("arst_idx", rd_idx, 0);
    chk("arst_fill", fill_cnt, 0);
    chk("arst_ovw", ovw_err, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_ready = 1'b0;
    tick();
    chk("post_rst_valid", rd_valid, 0);
    chk("post_rst_fill", fill_cnt, 0);

    // small instance: SEG=6, address 6 on channel 0 is out of range
    s_wr_en = 2'b01;
    s_wr_addr = {3'd0, 3'd6};
    s_wr_data = {12'h000, 12'hBAD};
    tick();
    s_wr_en = '0;
    chk("s_aerr", s_aerr, 1);
    chk("s_fill0", s_fill, 0);
    s_wr_en = 2'b10;
    s_wr_addr = {3'd5, 3'd0};
    s_wr_data = {12'h5A7, 12'h000};
    tick();
    s_wr_en = '0;
    chk("s_fill1", s_fill, 1);
    chk("s_aerr_sticky", s_aerr, 1);
    chk("s_ovw", s_ovw, 0);
    s_ready = 1'b1;
    s_rd_start = 1'b1;
    tick();
    s_rd_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("s_valid", s_valid, 1);
      chk("s_idx", s_idx, i);
      chk("s_data", s_data, (i == 11) ? 12'h5A7 : 12'h000);
      chk("s_last", s_last, i == 11);
      tick();
    end
    chk("s_end_valid", s_valid, 0);
    s_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qr_mat_ram.md
# qr_mat_ram

Parametrised multi-channel matrix store for the QR-CORDIC datapath, generalising the fixed 8-channel Q RAM and 32-entry R RAM into one block. CH write channels each own a contiguous row block of a ROWS×COLS matrix and can all write in the same cycle. The block tracks which entries have been written, flags double writes and bad addresses, and streams the whole matrix row-major through a valid/ready read port for checking or downstream use.

## Interface
- DATA_W, 12, element width (signed two's complement)
- ROWS, 8, matrix rows; must be a multiple of CH
- COLS, 8, matrix columns
- CH, 8, write channel count
- SEG, ROWS*COLS/CH (derived), entries per channel
- AW, clog2(SEG) (derived, min 1), local address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of contents, bitmap, errors, stream
- wr_en  in  CH  per-channel write strobe
- wr_addr  in  CH*AW  channel k local address in bits [k*AW +: AW]
- wr_data  in  CH*DATA_W  channel k data in bits [k*DATA_W +: DATA_W]
- fill_cnt  out  clog2(ROWS*COLS+1)  distinct entries written since clear
- full  out  1  fill_cnt == ROWS*COLS
- ovw_err  out  1  sticky: an already-written entry was written again
- addr_err  out  1  sticky: write with local address >= SEG
- rd_start  in  1  pulse: begin streaming
- rd_busy  out  1  stream in progress
- rd_valid  out  1  rd_data holds an element
- rd_ready  in  1  consumer accepts element
- rd_data  out  DATA_W  streamed element
- rd_idx  out  clog2(ROWS*COLS)  row-major index of rd_data
- rd_last  out  1  rd_data is element ROWS*COLS-1

## Operation
- Mapping: channel k, local address a -> global index g = k*SEG + a (row-major, row = g/COLS).
- Channel blocks are disjoint; simultaneous writes from different channels never collide.
- Per cycle, for each k with wr_en[k] and a < SEG: mem[g] <= data; written[g] <= 1; if written[g] was already 1, set ovw_err (write still performed).
- wr_en[k] with a >= SEG: no store, addr_err <= 1.
- fill_cnt increments by the number of entries newly marked this cycle (0..CH); saturates by construction at ROWS*COLS.
- clr: mem, written, fill_cnt, ovw_err, addr_err -> 0; aborts stream (to IDLE). Writes in the same cycle as clr are discarded.
- Read FSM, states IDLE, STREAM:
  - IDLE: rd_start -> STREAM, load mem[0] into rd_data, rd_idx=0. rd_start in STREAM ignored.
  - STREAM: rd_valid=1. On rd_valid & rd_ready: if rd_idx == ROWS*COLS-1 -> IDLE (rd_valid=0); else load mem[rd_idx+1].
  - While rd_valid & !rd_ready: rd_data, rd_idx, rd_last held stable.
- Elements are sampled when loaded; writes to an entry after it was loaded do not affect the stream; writes to not-yet-loaded entries do. A write and a load of the same entry in the same cycle returns the old value.
- rd_busy = (state == STREAM). rd_last = rd_valid & (rd_idx == ROWS*COLS-1).

## Timing
- rst asserted: immediately all outputs 0, state IDLE, mem and written cleared; stream aborted mid-operation.
- Write-to-visible: a write at edge n is reflected in fill_cnt/full/errors after edge n and readable by a load at edge n+1.
- Read latency: rd_start sampled at edge n -> rd_valid=1 with element 0 after edge n.
- Full-throughput stream (rd_ready held 1): one element per cycle; ROWS*COLS cycles from first valid to rd_valid drop.
- rd_valid never deasserts without a handshake except on clr or rst.
- No combinational path from rd_ready to rd_valid/rd_data.

## Test plan
- Defaults, all 8 channels write a=0..7 over 8 cycles with data 8k+a -> fill_cnt 8,16,..,64, full=1 after cycle 8, ovw_err=0; stream with rd_ready=1 yields 0..63 in order, rd_last only on idx 63.
- Rewrite channel 3 address 5 after full -> ovw_err=1, fill_cnt stays 64, streamed element 29 shows new data.
- CH=2, ROWS=4, COLS=3 (SEG=6): write a=6 on channel 0 -> addr_err=1, no store, fill_cnt unchanged; a=5 on channel 1 lands at idx 11.
- Stream with rd_ready toggling 1,0,0,1 pattern -> rd_data/rd_idx stable during stalls, all 64 elements delivered exactly once, rd_start mid-stream ignored.
- Write to idx 40 (channel 5, a=0) during a stream paused at idx 10 -> streamed idx 40 shows new value; write to idx 5 at same time -> stream already past, unaffected.
- Assert clr at idx 20 of stream, then rst at idx 3 of a new stream -> rd_valid 0 next cycle after clr, all outputs 0 immediately on rst, fill_cnt 0 and errors cleared in both cases.
